// File: rtl/sa_fifo_ctrl_19x80_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_fifo_ctrl_19x80_pkg
// Description : Shared constants and pointer helper for the 19x80 FIFO
//               controller wrapping the two-port RAM macro.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_fifo_ctrl_19x80_pkg;

  localparam int DEPTH      = 19;                       // RAM entries
  localparam int WIDTH      = 80;                       // data width
  localparam int AW         = 5;                        // RAM address width
  localparam int OBUF_DEPTH = 3;                        // output skid entries
  localparam int CW         = $clog2(DEPTH + 1);        // RAM occupancy width
  localparam int OCW        = $clog2(OBUF_DEPTH + 1);   // skid occupancy width
  localparam int CRW        = OCW + 1;                  // read-credit arithmetic width

  // Advance a RAM pointer, wrapping from the last entry back to zero.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_fifo_obuf.sv
`default_nettype none
// ============================================================================
// Module      : sa_fifo_obuf
// Description : Small register FIFO used as the output skid buffer. Push is
//               unconditional (the caller guarantees space); pop follows the
//               valid/ready handshake on the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_fifo_obuf #(
  parameter  int DEPTH = 3,
  parameter  int WIDTH = 80,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             pop;

  function automatic logic [PW-1:0] idx_inc(input logic [PW-1:0] idx);
    if (idx == PW'(DEPTH - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid & pop_ready;
  assign out_data  = mem[head];

  // Storage: data entries need no reset, only the pointers and count do.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

  // Pointer/count bookkeeping; simultaneous push and pop at full is legal
  // because the head is read out before the slot is overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      assert (!(push && !pop && (count == CW'(DEPTH))));
      if (push) begin
        tail <= idx_inc(tail);
      end
      if (pop) begin
        head <= idx_inc(head);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sa_fifo_ctrl_19x80.sv
`default_nettype none
// ============================================================================
// Module      : sa_fifo_ctrl_19x80
// Description : Valid/ready FIFO controller around the 19x80 two-port RAM
//               macro. Issues reads ahead into a 3-entry skid buffer so the
//               two-cycle RAM read latency is hidden under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_fifo_ctrl_19x80
  import sa_fifo_ctrl_19x80_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  output logic             ram_byp_sel,
  output logic [WIDTH-1:0] ram_dbyp,
  output logic [31:0]      ram_pwrbus_pd,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [4:0]       ram_count
);

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic           re_d1;
  logic           re_d2;
  logic           push;
  logic           issue;
  logic           pop;
  logic           obuf_valid;
  logic [OCW-1:0] obuf_cnt;
  logic [CRW-1:0] credit_used;

  // Ready comes from the registered count, so a slot freed by a read issue
  // is rewritten no earlier than the following cycle; the RAM output
  // register therefore captures the old word on that same edge.
  assign in_ready = ~rst & (count_q < CW'(DEPTH));
  assign push     = in_valid & in_ready;

  assign out_valid = obuf_valid & ~rst;
  assign pop       = out_valid & out_ready;

  // Skid slots are claimed by words already buffered plus reads in flight.
  // A word leaving the buffer this cycle releases its slot to this cycle's
  // issue, which is what sustains one word per cycle in steady state.
  assign credit_used = CRW'(re_d1) + CRW'(re_d2) + CRW'(obuf_cnt);
  assign issue       = ~rst & (count_q != '0) &
                       (credit_used < (CRW'(OBUF_DEPTH) + CRW'(pop)));

  assign ram_we        = push;
  assign ram_wa        = wr_ptr;
  assign ram_di        = in_data;
  assign ram_re        = issue;
  assign ram_ra        = rd_ptr;
  assign ram_ore       = re_d1;
  assign ram_byp_sel   = 1'b0;
  assign ram_dbyp      = '0;
  assign ram_pwrbus_pd = '0;
  assign ram_count     = count_q;

  // Pointers, RAM occupancy and the read-latency valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      re_d1   <= 1'b0;
      re_d2   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (issue) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count_q <= count_q + CW'(push) - CW'(issue);
      re_d1   <= issue;
      re_d2   <= re_d1;
    end
  end

  sa_fifo_obuf #(
    .DEPTH (OBUF_DEPTH),
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (re_d2),
    .push_data (ram_dout),
    .pop_ready (out_ready),
    .out_valid (obuf_valid),
    .out_data  (out_data),
    .count     (obuf_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_sa_fifo_ctrl_19x80.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_fifo_ctrl_19x80
// Description : Self-checking bench for sa_fifo_ctrl_19x80 with a behavioural
//               model of the two-port RAM macro and a data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_fifo_ctrl_19x80;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] out_data;
  logic [4:0]  ram_wa;
  logic        ram_we;
  logic [79:0] ram_di;
  logic [4:0]  ram_ra;
  logic        ram_re;
  logic        ram_ore;
  logic        ram_byp_sel;
  logic [79:0] ram_dbyp;
  logic [31:0] ram_pwrbus_pd;
  logic [79:0] ram_dout;
  logic [4:0]  ram_count;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  int n_out = 0;
  logic [79:0] sb [$];

  always #5 clk = ~clk;

  sa_fifo_ctrl_19x80 dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .ram_wa        (ram_wa),
    .ram_we        (ram_we),
    .ram_di        (ram_di),
    .ram_ra        (ram_ra),
    .ram_re        (ram_re),
    .ram_ore       (ram_ore),
    .ram_byp_sel   (ram_byp_sel),
    .ram_dbyp      (ram_dbyp),
    .ram_pwrbus_pd (ram_pwrbus_pd),
    .ram_dout      (ram_dout),
    .ram_count     (ram_count)
  );

  // RAM macro model: registered read address, output register enable.
  logic [79:0] mem [0:18];
  logic [4:0]  ra_q;
  logic [79:0] dout_q;
  always @(posedge clk) begin
    if (ram_we && ram_wa < 5'd19) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
    if (ram_ore && ra_q < 5'd19) dout_q <= mem[ra_q];
  end
  assign ram_dout = dout_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and occupancy model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
    end else begin
      chk("ram_count", 32'(ram_count), exp_cnt);
      if (ram_we) chk("wa_range", 32'(ram_wa < 5'd19), 1);
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chkd("out_data", out_data, sb.pop_front());
        n_out++;
      end
      exp_cnt = exp_cnt + ((in_valid && in_ready) ? 1 : 0) - (ram_re ? 1 : 0);
    end
  end

  initial begin
    int nacc, nout, first, bubbles, sent, wraps, rwraps, stalls, base;
    logic acc;
    logic [95:0] tmp;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ram_en", 32'({ram_we, ram_re, ram_ore}), 0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_count", 32'(ram_count), 0);
    chk("post_rst_out_valid", 32'(out_valid), 0);

    // Single-word latency
    cyc(); in_valid = 1'b1; in_data = 80'hA5; out_ready = 1'b1;
    @(negedge clk); chk("lat_accept", 32'(in_ready), 1);
    cyc(); in_valid = 1'b0;
    @(negedge clk); chk("lat_re_c1", 32'(ram_re), 1); chk("lat_ore_c1", 32'(ram_ore), 0);
    cyc(); @(negedge clk); chk("lat_ore_c2", 32'(ram_ore), 1); chk("lat_ov_c2", 32'(out_valid), 0);
    cyc(); @(negedge clk); chk("lat_ov_c3", 32'(out_valid), 0);
    cyc(); @(negedge clk); chk("lat_ov_c4", 32'(out_valid), 1); chkd("lat_data", out_data, 80'hA5);
    repeat (5) cyc();

    // Capacity under full backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = '0; nacc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); acc = in_ready;
      cyc();
      if (acc) begin nacc++; in_data = in_data + 80'd1; end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("cap_accepted", nacc, 22);
    chk("cap_ram_count", 32'(ram_count), 19);
    chk("cap_in_ready", 32'(in_ready), 0);
    chk("cap_out_valid", 32'(out_valid), 1);

    // Drain: 22 words back to back
    cyc(); out_ready = 1'b1; nout = 0; first = -1; bubbles = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin if (first < 0) first = c; nout++; end
      else if (first >= 0 && nout < 22) bubbles++;
      cyc();
    end
    chk("drain_count", nout, 22);
    chk("drain_bubbles", bubbles, 0);
    chk("drain_sb_empty", 32'(sb.size()), 0);

    // 50-word stream, both pointers wrap twice
    in_valid = 1'b1; out_ready = 1'b1; in_data = '0;
    sent = 0; nout = 0; first = -1; bubbles = 0; wraps = 0; rwraps = 0; stalls = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (ram_we && ram_wa == 5'd18) wraps++;
      if (ram_re && ram_ra == 5'd18) rwraps++;
      if (in_valid && !in_ready) stalls++;
      if (out_valid) begin if (first < 0) first = c; nout++; end
      else if (first >= 0 && nout < 50) bubbles++;
      cyc();
      if (acc) begin
        sent++; in_data = in_data + 80'd1;
        if (sent == 50) in_valid = 1'b0;
      end
    end
    chk("stream_sent", sent, 50);
    chk("stream_out", nout, 50);
    chk("stream_first", first, 4);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_stalls", stalls, 0);
    chk("stream_wr_wraps", wraps, 2);
    chk("stream_rd_wraps", rwraps, 2);

    // Random traffic, 10k words
    sent = 0; base = n_out;
    tmp = {$urandom(), $urandom(), $urandom()}; in_data = tmp[79:0];
    for (int c = 0; c < 40000 && (n_out - base) < 10000; c++) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk); acc = in_valid && in_ready;
      cyc();
      if (acc) begin
        sent++;
        tmp = {$urandom(), $urandom(), $urandom()}; in_data = tmp[79:0];
      end
    end
    in_valid = 1'b0;
    chk("rand_sent", sent, 10000);
    chk("rand_received", n_out - base, 10000);
    chk("rand_sb_empty", 32'(sb.size()), 0);

    // Reset with words resident and reads in flight
    out_ready = 1'b0; in_valid = 1'b1; nacc = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = 80'(100 + i);
      @(negedge clk); if (in_ready) nacc++;
      cyc();
    end
    in_valid = 1'b0;
    chk("mid_acc", nacc, 5);
    rst = 1'b1; sb.delete();
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_count", 32'(ram_count), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    cyc(); in_valid = 1'b1; in_data = 80'h3C; out_ready = 1'b1;
    nout = 0; first = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) chk("mid_accept", 32'(in_ready), 1);
      if (out_valid) begin
        if (first < 0) begin first = c; chkd("mid_data", out_data, 80'h3C); end
        nout++;
      end
      cyc();
      if (c == 0) in_valid = 1'b0;
    end
    chk("mid_first", first, 4);
    chk("mid_only_one", nout, 1);
    chk("mid_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
